// File: rtl/axi4_duth_noc_pkg.sv
// Shared NoC helpers: small elaboration-time functions used to size indices and counters.
package axi4_duth_noc_pkg;

  function automatic int get_max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index width that never collapses to zero bits, even for a single requester.
  function automatic int get_log2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deser_shared_arb_if.sv
// Bundle between the per-port serial link FIFOs, the shared-deserializer arbiter and the deserializer.
interface deser_shared_arb_if
  import axi4_duth_noc_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SER_WIDTH = 16,
  parameter int COUNT_0   = 2,
  parameter int COUNT_1   = 1
);
  localparam int IW     = get_log2_min1(N_REQ);
  localparam int BEAT_W = $clog2(get_max2(COUNT_0, COUNT_1)) + 1;

  // Beat transfers on a requester port or the deserializer port when valid & ready in the
  // same cycle; valid never waits on ready, ready is combinational from ser_ready_in.
  logic [N_REQ-1:0]           req_valid_in;
  logic [N_REQ-1:0]           req_sel_in;
  logic [N_REQ*SER_WIDTH-1:0] req_data_in;
  logic [N_REQ-1:0]           req_ready_out;
  logic [SER_WIDTH-1:0]       ser_data_out;
  logic                       ser_valid_out;
  logic                       ser_count_sel;
  logic                       ser_ready_in;
  logic [IW-1:0]              grant_id;
  logic                       busy;
  logic [BEAT_W-1:0]          dbg_beat_o;
  logic [IW-1:0]              dbg_ptr_o;

  modport master (
    output req_valid_in, req_sel_in, req_data_in, ser_ready_in,
    input  req_ready_out, ser_data_out, ser_valid_out, ser_count_sel,
    input  grant_id, busy, dbg_beat_o, dbg_ptr_o
  );

  modport slave (
    input  req_valid_in, req_sel_in, req_data_in, ser_ready_in,
    output req_ready_out, ser_data_out, ser_valid_out, ser_count_sel,
    output grant_id, busy, dbg_beat_o, dbg_ptr_o
  );
endinterface

// File: rtl/rr_pick_gen.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping around.
module rr_pick_gen
  import axi4_duth_noc_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = get_log2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic found;
  int   cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = IW'(cand);
      end
    end
  end

  assign any_o = found;
endmodule

// File: rtl/deser_shared_arb.sv
// Shares one two-mode deserializer between N_REQ serial requesters, holding the grant for a
// whole packet so count_sel never changes mid-packet.
module deser_shared_arb
  import axi4_duth_noc_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SER_WIDTH = 16,
  parameter int COUNT_0   = 2,
  parameter int COUNT_1   = 1
) (
  input  logic             clk,
  input  logic             rst,
  deser_shared_arb_if.slave bus
);
  localparam int COUNT_MAX = get_max2(COUNT_0, COUNT_1);
  localparam int BEAT_W    = $clog2(COUNT_MAX) + 1;
  localparam int IW        = get_log2_min1(N_REQ);
  localparam logic [BEAT_W-1:0] C0_W = BEAT_W'(COUNT_0);
  localparam logic [BEAT_W-1:0] C1_W = BEAT_W'(COUNT_1);

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  arb_state_t        state_q;
  logic [IW-1:0]     ptr_q, own_q;
  logic              sel_q;
  logic [BEAT_W-1:0] beat_q;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              locked;
  logic [IW-1:0]     cur_idx;
  logic              cur_sel, cur_valid, xfer;
  logic [BEAT_W-1:0] count_c;

  rr_pick_gen #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i (bus.req_valid_in),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Locked outputs follow the owner only; the owner's live mode input is ignored.
  assign locked    = (state_q == ARB_LOCKED);
  assign cur_idx   = locked ? own_q : (pick_any ? pick_idx : ptr_q);
  assign cur_sel   = locked ? sel_q : (pick_any & bus.req_sel_in[pick_idx]);
  assign cur_valid = locked ? bus.req_valid_in[own_q] : pick_any;
  assign count_c   = cur_sel ? C1_W : C0_W;
  assign xfer      = cur_valid & bus.ser_ready_in;

  assign bus.ser_data_out  = bus.req_data_in[cur_idx*SER_WIDTH +: SER_WIDTH];
  assign bus.ser_valid_out = cur_valid;
  assign bus.ser_count_sel = cur_sel;
  assign bus.grant_id      = cur_idx;
  assign bus.busy          = locked;
  assign bus.dbg_beat_o    = beat_q;
  assign bus.dbg_ptr_o     = ptr_q;
  assign bus.req_ready_out = {N_REQ{bus.ser_ready_in}} &
    (locked ? ((N_REQ'(1) << own_q) & {N_REQ{cur_valid}}) : pick_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      sel_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (xfer) begin
            // Single-beat packets complete without ever taking the lock.
            if (count_c == BEAT_W'(1)) begin
              ptr_q <= next_ptr(pick_idx);
            end else begin
              state_q <= ARB_LOCKED;
              own_q   <= pick_idx;
              sel_q   <= cur_sel;
              beat_q  <= BEAT_W'(1);
            end
          end
        end
        ARB_LOCKED: begin
          if (xfer) begin
            if (beat_q == count_c - BEAT_W'(1)) begin
              state_q <= ARB_IDLE;
              ptr_q   <= next_ptr(own_q);
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deser_shared_arb.sv
// Directed bench for deser_shared_arb: the driver pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_deser_shared_arb;
  localparam int W = 29;

  logic clk;
  logic rst;
  logic [W-1:0] exp_q[$];
  int n_tests;
  int n_fail;
  int n_pushed;

  deser_shared_arb_if #(.N_REQ(4), .SER_WIDTH(16), .COUNT_0(2), .COUNT_1(1)) bus ();

  deser_shared_arb #(.N_REQ(4), .SER_WIDTH(16), .COUNT_0(2), .COUNT_1(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] data_of(input logic [1:0] g);
    logic [63:0] tbl;
    tbl = 64'hD3D3_C2C2_B1B1_A0A0;
    return tbl[g*16 +: 16];
  endfunction

  // Driver: apply one cycle of inputs and the outputs expected in that cycle.
  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] s, input logic rdy,
                      input logic eb, input logic ev, input logic es, input logic [1:0] eg,
                      input logic [3:0] er, input logic [1:0] ebt, input logic [1:0] ep);
    rst              = r;
    bus.req_valid_in = v;
    bus.req_sel_in   = s;
    bus.ser_ready_in = rdy;
    exp_q.push_back({eb, ev, es, eg, er, data_of(eg), ebt, ep});
    n_pushed++;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {bus.busy, bus.ser_valid_out, bus.ser_count_sel, bus.grant_id, bus.req_ready_out,
             bus.ser_data_out, bus.dbg_beat_o, bus.dbg_ptr_o};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL cycle_check #%0d: got busy/vld/sel/gid/rdy/data/beat/ptr=%h required=%h",
                 n_tests, got, e);
      end
    end
  end

  initial begin
    int g;
    n_tests  = 0;
    n_fail   = 0;
    n_pushed = 0;
    rst              = 1'b1;
    bus.req_valid_in = '0;
    bus.req_sel_in   = '0;
    bus.req_data_in  = 64'hD3D3_C2C2_B1B1_A0A0;
    bus.ser_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state with quiet inputs
    step(0, 4'h0, 4'h0, 0, 0, 0, 0, 2'd0, 4'h0, 2'd0, 2'd0);

    // All four valid in mode 0: grants 0,0,1,1,2,2,3,3,0,0
    for (int k = 0; k < 10; k++) begin
      g = (k / 2) % 4;
      step(0, 4'hF, 4'h0, 1, 1'(k % 2), 1, 0, 2'(g), 4'(1 << g), 2'(k % 2), 2'(g));
    end

    // Advance pointer to 2 with a single-beat packet from requester 1
    step(0, 4'b0010, 4'b0010, 1, 0, 1, 1, 2'd1, 4'b0010, 2'd0, 2'd1);
    // Req 2 (mode 1) then req 3 (mode 0)
    step(0, 4'b1100, 4'b0100, 1, 0, 1, 1, 2'd2, 4'b0100, 2'd0, 2'd2);
    step(0, 4'b1100, 4'b0100, 1, 0, 1, 0, 2'd3, 4'b1000, 2'd0, 2'd3);
    step(0, 4'b1000, 4'b0000, 1, 1, 1, 0, 2'd3, 4'b1000, 2'd1, 2'd3);
    step(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 2'd0, 2'd0);

    // Owner 1 stalls on valid for 3 cycles while requester 0 waits
    step(0, 4'b0010, 4'b0000, 1, 0, 1, 0, 2'd1, 4'b0010, 2'd0, 2'd0);
    repeat (3) step(0, 4'b0001, 4'b0000, 1, 1, 0, 0, 2'd1, 4'b0000, 2'd1, 2'd0);
    step(0, 4'b0011, 4'b0000, 1, 1, 1, 0, 2'd1, 4'b0010, 2'd1, 2'd0);
    step(0, 4'b0001, 4'b0000, 1, 0, 1, 0, 2'd0, 4'b0001, 2'd0, 2'd2);
    step(0, 4'b0001, 4'b0000, 1, 1, 1, 0, 2'd0, 4'b0001, 2'd1, 2'd2);

    // Owner mode input toggles while locked: latched mode wins
    step(0, 4'b0010, 4'b0000, 1, 0, 1, 0, 2'd1, 4'b0010, 2'd0, 2'd1);
    step(0, 4'b0010, 4'b0010, 1, 1, 1, 0, 2'd1, 4'b0010, 2'd1, 2'd1);
    step(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd2, 4'b0000, 2'd0, 2'd2);

    // Deserializer back-pressure for 4 cycles mid-packet
    step(0, 4'b0100, 4'b0000, 1, 0, 1, 0, 2'd2, 4'b0100, 2'd0, 2'd2);
    repeat (4) step(0, 4'b0100, 4'b0000, 0, 1, 1, 0, 2'd2, 4'b0000, 2'd1, 2'd2);
    step(0, 4'b0100, 4'b0000, 1, 1, 1, 0, 2'd2, 4'b0100, 2'd1, 2'd2);
    step(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd3, 4'b0000, 2'd0, 2'd3);

    // Reset while locked, then a fresh full packet from requester 0
    step(0, 4'b1000, 4'b0000, 1, 0, 1, 0, 2'd3, 4'b1000, 2'd0, 2'd3);
    step(1, 4'b1000, 4'b0000, 1, 1, 1, 0, 2'd3, 4'b1000, 2'd1, 2'd3);
    step(0, 4'b0001, 4'b0000, 1, 0, 1, 0, 2'd0, 4'b0001, 2'd0, 2'd0);
    step(0, 4'b0001, 4'b0000, 1, 1, 1, 0, 2'd0, 4'b0001, 2'd1, 2'd0);
    step(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd1, 4'b0000, 2'd0, 2'd1);

    repeat (3) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0 || n_tests != n_pushed + 1) begin
      n_fail++;
      $display("FAIL drain: queue left %0d, checks %0d, required pushed %0d",
               exp_q.size(), n_tests - 1, n_pushed);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/deser_shared_arb.md
# deser_shared_arb

Round-robin arbiter and sequencer that shares one two-mode deserializer (`deser_shared_gen`) between N_REQ serial requesters. It picks a requester and drives the deserializer's `count_sel` from that requester's mode. It holds the grant until the full packet of COUNT_0 or COUNT_1 beats has been accepted, so `count_sel` never changes mid-packet. It sits between the per-port serial link FIFOs and the shared deserializer in the NoC network interface.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥1.
- `SER_WIDTH`, 16: beat width.
- `COUNT_0`, 2: beats per packet when mode = 0, ≥1.
- `COUNT_1`, 1: beats per packet when mode = 1, ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_in` in N_REQ: per-requester beat valid.
- `req_sel_in` in N_REQ: per-requester mode (0 → COUNT_0, 1 → COUNT_1).
- `req_data_in` in N_REQ*SER_WIDTH: beats; requester i occupies slice [i*SER_WIDTH +: SER_WIDTH].
- `req_ready_out` out N_REQ: per-requester ready.
- `ser_data_out` out SER_WIDTH: beat to the deserializer `serial_in`.
- `ser_valid_out` out 1: to the deserializer `valid_in`.
- `ser_count_sel` out 1: to the deserializer `count_sel`.
- `ser_ready_in` in 1: from the deserializer `ready_out`.
- `grant_id` out $clog2(N_REQ) (min 1): index of the current or pending owner.
- `busy` out 1: high while LOCKED.

## Operation
- Two states:
  - IDLE: no owner.
  - LOCKED: owner `own_q`, latched mode `sel_q`, beat counter `beat_q`.
- IDLE:
  - The winner w is the first requester with `req_valid_in` set, searching from `ptr_q` upward with wrap.
  - The grant is combinational: `grant_id` = w, `ser_count_sel` = `req_sel_in[w]`, `ser_valid_out` = `req_valid_in[w]`, `ser_data_out` = w's slice.
  - No valid requester: `ser_valid_out` = 0, `grant_id` = `ptr_q`, `ser_count_sel` = 0.
- Handshake: a beat transfers when `ser_valid_out & ser_ready_in`. `req_ready_out[i]` = `ser_ready_in` & (i is the current/pending owner); it is 0 for all others.
- Let C = `sel` ? COUNT_1 : COUNT_0, using `req_sel_in[w]` in IDLE and `sel_q` in LOCKED.
- First beat in IDLE:
  - If C = 1: the packet is done. Stay in IDLE, set `ptr_q` ← (w+1) mod N_REQ.
  - Otherwise: go to LOCKED with `own_q` ← w, `sel_q` ← `req_sel_in[w]`, `beat_q` ← 1.
- LOCKED:
  - The outputs come from `own_q`/`sel_q`. `req_sel_in[own_q]` is ignored.
  - On each transfer, `beat_q` increments.
  - On the transfer with `beat_q` = C−1: return to IDLE, set `ptr_q` ← (`own_q`+1) mod N_REQ, clear `beat_q`.
- An owner that drops valid mid-packet keeps the lock. `ser_valid_out` = 0 and the arbiter waits with no timeout. Other requesters stay stalled.
- `beat_q` width is $clog2(COUNT_MAX)+1, where COUNT_MAX = max(COUNT_0, COUNT_1). It never exceeds COUNT_MAX−1.
- COUNT_0 = COUNT_1 = 1: LOCKED is unreachable and `busy` is constant 0.
- N_REQ = 1: arbitration degenerates to a pass-through with packet locking. `ptr_q` is constant 0.

## Timing
- Zero-cycle latency from requester to deserializer. The path is combinational: `req_valid_in`/`req_data_in` → `ser_*`, and `ser_ready_in` → `req_ready_out`.
- Reset values (after `rst` is sampled high at a clock edge): state IDLE, `ptr_q` = 0, `own_q` = 0, `sel_q` = 0, `beat_q` = 0, `busy` = 0.
  - With inputs quiet, the outputs settle to `ser_valid_out` = 0, `req_ready_out` = 0, `grant_id` = 0, `ser_count_sel` = 0.
- Reset mid-packet: the arbiter is in IDLE on the next cycle and any partial packet is discarded. The deserializer is reset by the same `rst`, so both sides realign.
- Packet completion and a new request in the same cycle: the new arbitration uses the updated `ptr_q`, one cycle later. There are no idle bubbles in LOCKED.
- Back-to-back packets from the same requester: allowed only if no other requester is valid, because the pointer moves past the last owner.
- Fairness: any continuously valid requester is granted within N_REQ−1 packets.

## Structure
- Shared package `axi4_duth_noc_pkg`: reuse `get_max2`. Add `get_log2_min1(n)`, which returns max(1, $clog2(n)), for the index widths.
- State enum `arb_state_t {ARB_IDLE, ARB_LOCKED}`: local to the module.
- One sub-module, `rr_pick_gen #(N)`: a combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
- Remaining logic: the FSM, beat counter and output muxes, in `deser_shared_arb`.

## Test plan
- N_REQ=4, COUNT_0=2, COUNT_1=1, all 4 requesters valid with mode 0, `ser_ready_in`=1 → grants 0,0,1,1,2,2,3,3,0… Each grant lasts 2 cycles and `ser_count_sel`=0 throughout.
- Requester 2 mode 1 and requester 3 mode 0 both valid, `ptr_q`=2 → one cycle granting 2 (`busy`=0, `ser_count_sel`=1), then 2 cycles granting 3 (`busy`=1 on the second, `ser_count_sel`=0).
- Owner 1 locked after beat 1 of 2; it drops valid for 3 cycles while requester 0 is valid → `ser_valid_out`=0, `req_ready_out`=0000, `grant_id`=1. Beat 2 completes when valid returns; requester 0 is granted next.
- `req_sel_in[own]` toggled 0→1 during LOCKED → `ser_count_sel` stays 0 and the packet still completes after 2 beats.
- `ser_ready_in`=0 for 4 cycles mid-packet → `beat_q` holds and no `req_ready_out` is asserted. The packet resumes correctly afterwards.
- `rst` asserted while LOCKED at `beat_q`=1 → next cycle: IDLE, `ptr_q`=0, `busy`=0. A fresh packet from requester 0 then takes the full 2 beats.
